// File: rtl/reg_snap_pkg.sv
// Shared encodings and frame layout for the register snapshot transmitter.
// REG_SNAP_CKSUM_EN appends an XOR checksum word, so the frame grows by one.
package reg_snap_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int IDX_PC    = 0;
  localparam int IDX_S0    = 1;
  localparam int IDX_T0    = 9;
  localparam int IDX_CKSUM = 19;

  function automatic int frame_len(input int num_s, input int num_t);
`ifdef REG_SNAP_CKSUM_EN
    return 2 + num_s + num_t;
`else
    return 1 + num_s + num_t;
`endif
  endfunction

  localparam int FRAME_LEN = frame_len(8, 10);

endpackage

// File: rtl/reg_snapshot_tx_if.sv
// Valid/ready word stream from the snapshot transmitter to its consumer.
// Producer holds data/index/last stable while valid && !ready.
interface reg_snapshot_tx_if #(
  parameter int DATA_W = 32
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [4:0]        tx_index;
  logic              tx_last;

  modport master (output tx_valid, tx_data, tx_index, tx_last, input tx_ready);
  modport slave  (input tx_valid, tx_data, tx_index, tx_last, output tx_ready);
endinterface

// File: rtl/reg_snapshot_tx_snap_word_mux.sv
// Combinational pick of the shadow word at a frame index; zero for unused indices.
// REG_SNAP_CKSUM_EN adds the XOR-of-all-words entry after the last $t word.
module snap_word_mux
  import reg_snap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_S  = 8,
  parameter int NUM_T  = 10
) (
  input  logic [4:0]              idx,
  input  logic [DATA_W-1:0]       pc,
  input  logic [NUM_S*DATA_W-1:0] s_regs,
  input  logic [NUM_T*DATA_W-1:0] t_regs,
  output logic [DATA_W-1:0]       word
);

  localparam int T0 = IDX_S0 + NUM_S;

`ifdef REG_SNAP_CKSUM_EN
  localparam int CK = T0 + NUM_T;
  logic [DATA_W-1:0] cksum;

  always_comb begin
    cksum = pc;
    for (int i = 0; i < NUM_S; i++) cksum = cksum ^ s_regs[i*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_T; i++) cksum = cksum ^ t_regs[i*DATA_W +: DATA_W];
  end
`endif

  always_comb begin
    word = '0;
    if (idx == 5'(IDX_PC)) word = pc;
    for (int i = 0; i < NUM_S; i++)
      if (idx == 5'(IDX_S0 + i)) word = s_regs[i*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_T; i++)
      if (idx == 5'(T0 + i)) word = t_regs[i*DATA_W +: DATA_W];
`ifdef REG_SNAP_CKSUM_EN
    if (idx == 5'(CK)) word = cksum;
`endif
  end

endmodule

// File: rtl/reg_snapshot_tx.sv
// Captures PC/$s/$t on snap_trigger and streams them one word per handshake (optional REG_SNAP_CKSUM_EN checksum word).
// First word valid one cycle after the trigger edge; outputs hold under !tx_ready, valid never depends on ready.
module reg_snapshot_tx
  import reg_snap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_S  = 8,
  parameter int NUM_T  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snap_trigger,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [NUM_S*DATA_W-1:0] s_regs_in,
  input  logic [NUM_T*DATA_W-1:0] t_regs_in,
  reg_snapshot_tx_if.master       tx,
  output logic                    busy,
  output logic                    overrun
);

  localparam int         N        = frame_len(NUM_S, NUM_T);
  localparam logic [4:0] LAST_IDX = 5'(N - 1);

  state_t                  state, state_nxt;
  logic [4:0]              idx, idx_nxt;
  logic                    capture;
  logic [DATA_W-1:0]       pc_sh;
  logic [NUM_S*DATA_W-1:0] s_sh;
  logic [NUM_T*DATA_W-1:0] t_sh;
  logic [DATA_W-1:0]       word;

  assign capture = (state == ST_IDLE) && snap_trigger;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (snap_trigger && state != ST_IDLE) overrun <= 1'b1;
    end
  end

  // Shadow contents are don't-care out of reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_sh <= pc_in;
      s_sh  <= s_regs_in;
      t_sh  <= t_regs_in;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (snap_trigger) begin
          state_nxt = ST_SEND;
          idx_nxt   = '0;
        end
      end
      ST_SEND: begin
        if (tx.tx_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 5'd1;
          end
        end
      end
    endcase
  end

  snap_word_mux #(
    .DATA_W(DATA_W),
    .NUM_S (NUM_S),
    .NUM_T (NUM_T)
  ) u_mux (
    .idx   (idx),
    .pc    (pc_sh),
    .s_regs(s_sh),
    .t_regs(t_sh),
    .word  (word)
  );

  // Gate data with valid so stale/unknown shadows never reach the bus when idle.
  assign tx.tx_valid = (state == ST_SEND);
  assign tx.tx_index = idx;
  assign tx.tx_last  = (state == ST_SEND) && (idx == LAST_IDX);
  assign tx.tx_data  = (state == ST_SEND) ? word : '0;
  assign busy        = (state != ST_IDLE);

endmodule

// File: doc/reg_snapshot_tx.md
Name: reg_snapshot_tx

Overview:
- Debug transmitter for the pipelined MIPS core.
- On a trigger, captures the architectural state the core exposes (PC, $s0-$s7, $t0-$t9) in one cycle, then streams it out one 32-bit word per handshake over a valid/ready interface.
- It is the hardware producer for the register-monitor interface. A downstream consumer (UART bridge, logic analyser, bench scoreboard) sits on the tx side.

Parameters:
- DATA_W, 32, width of every captured word and of tx_data.
- NUM_S, 8, number of $s registers captured.
- NUM_T, 10, number of $t registers captured.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- snap_trigger  in  1  request a snapshot; sampled on the clock edge
- pc_in  in  DATA_W  current PC tap (PCout_monitor)
- s_regs_in  in  NUM_S*DATA_W  $s0 in bits [31:0], $s7 in the top word
- t_regs_in  in  NUM_T*DATA_W  $t0 in bits [31:0], $t9 in the top word
- tx_valid  out  1  tx_data/tx_index/tx_last are valid
- tx_ready  in  1  consumer accepts the word this cycle
- tx_data  out  DATA_W  current word
- tx_index  out  5  word position within the frame, 0-based
- tx_last  out  1  current word is the final word of the frame
- busy  out  1  a capture is held or a frame is in flight
- overrun  out  1  sticky: a trigger arrived while busy

Behaviour:
- Frame order: index 0 = PC; 1-8 = $s0-$s7; 9-18 = $t0-$t9. Frame length N = 1+NUM_S+NUM_T = 19 (20 with the optional feature).
- FSM states:
  - IDLE -> SEND on snap_trigger. All inputs are copied into shadow registers at that edge.
  - SEND -> SEND on a handshake that is not the last word (index advances).
  - SEND -> IDLE on the handshake of the last word.
- Latency: trigger sampled at edge k -> tx_valid=1 with index 0 from edge k+1. Word values are those present at edge k.
- Handshake:
  - A transfer occurs when tx_valid && tx_ready at a rising edge.
  - While tx_valid=1 and tx_ready=0, tx_data, tx_index and tx_last are held stable.
  - tx_valid never drops without a transfer, except on reset.
  - tx_valid is never combinationally dependent on tx_ready.
- Throughput: one word per cycle with tx_ready held high. A full frame takes N cycles after the first valid.
- busy = (state != IDLE). tx_last = tx_valid && (tx_index == N-1).
- Trigger while busy, including the cycle of the final handshake: ignored, and overrun is set to 1. The shadow registers are not modified.
- Trigger in IDLE in the cycle immediately after a frame ends: accepted normally, so back-to-back frames are separated by one idle cycle.
- Shadow registers are stable for the whole frame; input changes during SEND have no effect.
- Reset values (including reset mid-frame, which takes effect at the next edge):
  - state = IDLE, tx_valid = 0, tx_index = 0, tx_last = 0, busy = 0, overrun = 0, tx_data = 0.
  - Shadow contents are don't-care.
- overrun clears only on reset.

Optional Feature:
- Macro: REG_SNAP_CKSUM_EN.
- Defined: a checksum word is appended at index 19, giving N = 20. Its value is the XOR of words 0-18, computed from the shadow registers. tx_last is asserted on index 19.
- Undefined: N = 19, no checksum logic, and tx_last is asserted on index 18.

Decomposition:
- Shared package/header (reg_snap_pkg), holding:
  - state encodings: ST_IDLE = 0, ST_SEND = 1;
  - frame index constants: IDX_PC = 0, IDX_S0 = 1, IDX_T0 = 9, IDX_CKSUM = 19;
  - FRAME_LEN derived from the macro.
- Sub-module snap_word_mux: combinational selection of the shadow word by tx_index.
- The FSM, counter, handshake and overrun logic stay in the top module.

Test Plan:
- Reset, then trigger with PC = 0x00400010, $s_i = 0x5000000i, $t_i = 0xA000000i, tx_ready held 1 -> 19 consecutive transfers in frame order. tx_last only on index 18. busy falls the cycle after the last transfer.
- Same frame with tx_ready toggled 1,0,0,1,... -> every word is delivered exactly once, in order. Outputs are held stable during every stall.
- Change all inputs to 0xDEADBEEF in the cycle after the trigger -> the frame still carries the originally captured values.
- Trigger at index 5, and again in the final-handshake cycle -> the frame is unaffected, overrun = 1 and stays 1. A trigger one cycle later starts a new frame.
- Assert reset while index = 7 with tx_valid = 1 -> next cycle tx_valid = 0, busy = 0, overrun = 0. A new trigger restarts the frame at index 0.
- With REG_SNAP_CKSUM_EN and $s0 = 0x1, all other words 0 -> index 19 carries 0x00000001 with tx_last = 1. Index 18 has tx_last = 0.
